// File: rtl/dm_store_rmw_if.sv
// Store request channel from the MEM stage plus the word-wide data memory port.
// slave: the store RMW block; master: the pipeline/memory side driving it.
interface dm_store_rmw_if;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned DATA_W = 32;

    logic              req_valid;
    logic              req_ready;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;

    logic [DATA_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;

    logic              done;
    logic              align_err;

    modport slave (
        input  req_valid, op, addr, wdata, mem_rdata, mem_rvalid,
        output req_ready, mem_addr, mem_rd, mem_wr, mem_wdata, done, align_err
    );

    modport master (
        output req_valid, op, addr, wdata, mem_rdata, mem_rvalid,
        input  req_ready, mem_addr, mem_rd, mem_wr, mem_wdata, done, align_err
    );
endinterface

// File: rtl/dm_store_rmw.sv
// SB/SH/SW store unit for a word-wide memory without byte enables:
// SW writes directly, SB/SH read the word, merge the lane and write it back.
module dm_store_rmw #(
    parameter int unsigned RD_TIMEOUT = 16,
    parameter int unsigned CNT_W      = 5,
    parameter logic [5:0]  OP_SB      = 6'h28,
    parameter logic [5:0]  OP_SH      = 6'h29,
    parameter logic [5:0]  OP_SW      = 6'h2B
) (
    input  logic           clk,
    input  logic           rst_n,
    dm_store_rmw_if.slave  io
);
    localparam int unsigned     DATA_W   = 32;
    localparam int unsigned     HALF_W   = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_ERR
    } state_t;

    state_t              r_state;
    logic                r_is_sh;
    logic [1:0]          r_lane;
    logic [HALF_W-1:0]   r_wdata;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_mem_rd;
    logic                r_mem_wr;
    logic                r_done;
    logic                r_align_err;
    logic                r_req_ready;

    state_t              w_state_nxt;
    logic                w_is_sh_nxt;
    logic [1:0]          w_lane_nxt;
    logic [HALF_W-1:0]   w_wdata_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [DATA_W-1:0]   w_mem_addr_nxt;
    logic [DATA_W-1:0]   w_mem_wdata_nxt;
    logic [DATA_W-1:0]   w_merged;

    // Little-endian lane merge of the pending store into the read word
    always_comb begin
        w_merged = io.mem_rdata;
        if (r_is_sh) begin
            w_merged[{r_lane[1], 4'b0000} +: HALF_W] = r_wdata;
        end else begin
            w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        end
    end

    // Next-state and next register values
    always_comb begin
        w_state_nxt     = r_state;
        w_is_sh_nxt     = r_is_sh;
        w_lane_nxt      = r_lane;
        w_wdata_nxt     = r_wdata;
        w_cnt_nxt       = r_cnt;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;

        case (r_state)
            ST_IDLE: begin
                if (io.req_valid) begin
                    w_is_sh_nxt    = (io.op == OP_SH);
                    w_lane_nxt     = io.addr[1:0];
                    w_wdata_nxt    = io.wdata[HALF_W-1:0];
                    w_mem_addr_nxt = {io.addr[DATA_W-1:2], 2'b00};
                    case (io.op)
                        OP_SW: begin
                            if (io.addr[1:0] != 2'b00) begin
                                w_state_nxt = ST_ERR;
                            end else begin
                                w_state_nxt     = ST_WRITE;
                                w_mem_wdata_nxt = io.wdata;
                            end
                        end
                        OP_SH:   w_state_nxt = io.addr[0] ? ST_ERR : ST_READ;
                        OP_SB:   w_state_nxt = ST_READ;
                        default: w_state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_READ: begin
                w_state_nxt = ST_WAIT;
                w_cnt_nxt   = '0;
            end
            ST_WAIT: begin
                // Read data wins over the timeout when both land together
                if (io.mem_rvalid) begin
                    w_state_nxt     = ST_WRITE;
                    w_mem_wdata_nxt = w_merged;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_ERR;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_WRITE: w_state_nxt = ST_IDLE;
            ST_ERR:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State and registered outputs; strobes follow the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_is_sh     <= 1'b0;
            r_lane      <= 2'b00;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_done      <= 1'b0;
            r_align_err <= 1'b0;
            r_req_ready <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_is_sh     <= w_is_sh_nxt;
            r_lane      <= w_lane_nxt;
            r_wdata     <= w_wdata_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_rd    <= (w_state_nxt == ST_READ);
            r_mem_wr    <= (w_state_nxt == ST_WRITE);
            r_done      <= (w_state_nxt == ST_WRITE);
            r_align_err <= (w_state_nxt == ST_ERR);
            r_req_ready <= (w_state_nxt == ST_IDLE);
        end
    end

    assign io.req_ready = r_req_ready;
    assign io.mem_addr  = r_mem_addr;
    assign io.mem_rd    = r_mem_rd;
    assign io.mem_wr    = r_mem_wr;
    assign io.mem_wdata = r_mem_wdata;
    assign io.done      = r_done;
    assign io.align_err = r_align_err;
endmodule
